// File: rtl/spike_pattern_sequencer.sv
// Multi-batch spike raster memory with host access and timestep-by-timestep replay over valid/ready.
// Define SPIKE_SEQ_LOOP_EN to add the loop_en input for continuous replay.
module spike_pattern_sequencer #(
  parameter int unsigned SPIKES_PER_BATCH   = 32,
  parameter int unsigned NUM_INPUTS         = 784,
  parameter int unsigned MAX_TIMESTEPS_BITS = 7,
  parameter int unsigned BATCH_ADDR_WIDTH   = 6
) (
`ifdef SPIKE_SEQ_LOOP_EN
  input  logic                          loop_en,
`endif
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic                          wr_en,
  input  logic [BATCH_ADDR_WIDTH-1:0]   wr_batch,
  input  logic [MAX_TIMESTEPS_BITS-1:0] wr_timestep,
  input  logic [SPIKES_PER_BATCH-1:0]   wr_data,
  input  logic                          rd_en,
  input  logic [BATCH_ADDR_WIDTH-1:0]   rd_batch,
  input  logic [MAX_TIMESTEPS_BITS-1:0] rd_timestep,
  output logic [SPIKES_PER_BATCH-1:0]   rd_data,
  output logic                          rd_valid,
  input  logic                          start,
  input  logic [MAX_TIMESTEPS_BITS-1:0] sim_time,
  output logic [NUM_INPUTS-1:0]         spikes_out,
  output logic                          spikes_valid,
  input  logic                          spikes_ready,
  output logic [MAX_TIMESTEPS_BITS-1:0] timestep,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned NumBatches = (NUM_INPUTS + SPIKES_PER_BATCH - 1) / SPIKES_PER_BATCH;
  localparam int unsigned Depth      = NumBatches << MAX_TIMESTEPS_BITS;
  localparam int unsigned AddrW      = $clog2(Depth);
  localparam int unsigned FetchW     = BATCH_ADDR_WIDTH + 1;
  localparam int          Spb        = int'(SPIKES_PER_BATCH);
  localparam int          NumIn      = int'(NUM_INPUTS);

  localparam logic [FetchW-1:0]             FetchLast = FetchW'(NumBatches);
  localparam logic [MAX_TIMESTEPS_BITS-1:0] TsOne     = MAX_TIMESTEPS_BITS'(1);

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StDone} state_e;

  // Raster is stored timestep-major: word address = timestep * NumBatches + batch.
  function automatic logic [AddrW-1:0] addr_of(input logic [MAX_TIMESTEPS_BITS-1:0] ts,
                                               input logic [BATCH_ADDR_WIDTH-1:0]   b);
    return AddrW'(32'(ts) * NumBatches + 32'(b));
  endfunction

  state_e                          state_q;
  logic [MAX_TIMESTEPS_BITS-1:0]   sim_time_q;
  logic [MAX_TIMESTEPS_BITS-1:0]   timestep_q;
  logic [FetchW-1:0]               fetch_idx_q;
  logic                            cap_valid_q;
  logic [BATCH_ADDR_WIDTH-1:0]     cap_idx_q;
  logic [NUM_INPUTS-1:0]           spikes_q, spikes_d;
  logic                            spikes_valid_q;
  logic                            busy_q;
  logic                            done_q;
  logic                            rd_valid_q;
  logic                            rd_inrange_q;

  logic [SPIKES_PER_BATCH-1:0]     mem [Depth];
  logic [SPIKES_PER_BATCH-1:0]     mem_a_q;
  logic [SPIKES_PER_BATCH-1:0]     mem_b_q;

  logic                            wr_fire;
  logic                            rd_inrange;
  logic [AddrW-1:0]                wr_addr;
  logic [AddrW-1:0]                rd_addr;
  logic                            rdb_en;
  logic [AddrW-1:0]                rdb_addr;
  logic                            loop_go;

`ifdef SPIKE_SEQ_LOOP_EN
  assign loop_go = loop_en;
`else
  assign loop_go = 1'b0;
`endif

  assign wr_fire    = wr_en && !busy_q && (32'(wr_batch) < NumBatches);
  assign wr_addr    = addr_of(wr_timestep, wr_batch);
  assign rd_inrange = 32'(rd_batch) < NumBatches;
  assign rd_addr    = rd_inrange ? addr_of(rd_timestep, rd_batch) : '0;
  assign rdb_en     = (state_q == StFetch) && (fetch_idx_q != FetchLast);
  assign rdb_addr   = addr_of(timestep_q, fetch_idx_q[BATCH_ADDR_WIDTH-1:0]);

  // Storage only; a same-address read and write in one cycle returns the old word.
  always_ff @(posedge S_AXI_ACLK) begin
    if (wr_fire) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      mem_a_q <= mem[rd_addr];
    end
    if (rdb_en) begin
      mem_b_q <= mem[rdb_addr];
    end
  end

  // Drop the captured word into its batch slot; bits past NUM_INPUTS are never placed.
  always_comb begin
    spikes_d = spikes_q;
    for (int i = 0; i < NumIn; i++) begin
      if ((i / Spb) == int'(cap_idx_q)) begin
        spikes_d[i] = mem_b_q[i % Spb];
      end
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q        <= StIdle;
      sim_time_q     <= '0;
      timestep_q     <= '0;
      fetch_idx_q    <= '0;
      cap_valid_q    <= 1'b0;
      cap_idx_q      <= '0;
      spikes_q       <= '0;
      spikes_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_inrange_q   <= 1'b0;
    end else begin
      rd_valid_q   <= rd_en;
      rd_inrange_q <= rd_en && rd_inrange;
      done_q       <= 1'b0;
      cap_valid_q  <= 1'b0;
      if (cap_valid_q) begin
        spikes_q <= spikes_d;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            sim_time_q  <= sim_time;
            timestep_q  <= '0;
            fetch_idx_q <= '0;
            if (sim_time == '0) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              busy_q  <= 1'b1;
              state_q <= StFetch;
            end
          end
        end

        StFetch: begin
          if (fetch_idx_q != FetchLast) begin
            fetch_idx_q <= fetch_idx_q + FetchW'(1);
            cap_valid_q <= 1'b1;
            cap_idx_q   <= fetch_idx_q[BATCH_ADDR_WIDTH-1:0];
          end else begin
            // The last batch is being captured on this same edge.
            spikes_valid_q <= 1'b1;
            state_q        <= StPresent;
          end
        end

        StPresent: begin
          if (spikes_ready) begin
            spikes_valid_q <= 1'b0;
            fetch_idx_q    <= '0;
            if (timestep_q == sim_time_q - TsOne) begin
              done_q <= 1'b1;
              if (loop_go) begin
                timestep_q <= '0;
                state_q    <= StFetch;
              end else begin
                busy_q  <= 1'b0;
                state_q <= StDone;
              end
            end else begin
              timestep_q <= timestep_q + TsOne;
              state_q    <= StFetch;
            end
          end
        end

        StDone: begin
          state_q <= StIdle;
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign rd_valid     = rd_valid_q;
  assign rd_data      = rd_inrange_q ? mem_a_q : '0;
  assign spikes_out   = spikes_q;
  assign spikes_valid = spikes_valid_q;
  assign timestep     = timestep_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_spike_pattern_sequencer.sv
// Directed bench for spike_pattern_sequencer: host port table plus replay corner-case sequences.
// Loop tests are compiled in when SPIKE_SEQ_LOOP_EN is defined.
module tb_spike_pattern_sequencer;

  localparam int NB = 25;
  localparam int NI = 784;

  logic         clk;
  logic         rst;
  logic         wr_en;
  logic [5:0]   wr_batch;
  logic [6:0]   wr_timestep;
  logic [31:0]  wr_data;
  logic         rd_en;
  logic [5:0]   rd_batch;
  logic [6:0]   rd_timestep;
  logic [31:0]  rd_data;
  logic         rd_valid;
  logic         start;
  logic [6:0]   sim_time;
  logic [NI-1:0] spikes_out;
  logic         spikes_valid;
  logic         spikes_ready;
  logic [6:0]   timestep;
  logic         busy;
  logic         done;
`ifdef SPIKE_SEQ_LOOP_EN
  logic         loop_en;
`endif

  int total = 0;
  int bad = 0;
  int done_seen = 0;

  logic [31:0] model [3][NB];

  spike_pattern_sequencer dut (
`ifdef SPIKE_SEQ_LOOP_EN
    .loop_en      (loop_en),
`endif
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .wr_en        (wr_en),
    .wr_batch     (wr_batch),
    .wr_timestep  (wr_timestep),
    .wr_data      (wr_data),
    .rd_en        (rd_en),
    .rd_batch     (rd_batch),
    .rd_timestep  (rd_timestep),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .start        (start),
    .sim_time     (sim_time),
    .spikes_out   (spikes_out),
    .spikes_valid (spikes_valid),
    .spikes_ready (spikes_ready),
    .timestep     (timestep),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1) done_seen++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_vec(input string name, input logic [NI-1:0] act, input logic [NI-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, output int n);
    n = 0;
    while (spikes_valid !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (spikes_valid !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL %s: spikes_valid timeout got 0 want 1", name);
    end
  endtask

  task automatic host_write(input int ts, input int b, input logic [31:0] d);
    wr_en = 1'b1;
    wr_timestep = 7'(ts);
    wr_batch = 6'(b);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    if (b < NB && ts < 3) model[ts][b] = d;
  endtask

  task automatic host_read(input int ts, input int b, output logic v, output logic [31:0] d);
    rd_en = 1'b1;
    rd_timestep = 7'(ts);
    rd_batch = 6'(b);
    tick();
    rd_en = 1'b0;
    v = rd_valid;
    d = rd_data;
  endtask

  task automatic pulse_start(input int st);
    sim_time = 7'(st);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [NI-1:0] assemble(input int ts);
    logic [NI-1:0] v;
    v = '0;
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < 32; i++) begin
        if (b * 32 + i < NI) v[b * 32 + i] = model[ts][b][i];
      end
    end
    return v;
  endfunction

  typedef struct {
    logic        we;
    logic [5:0]  wb;
    logic [6:0]  wt;
    logic [31:0] wd;
    logic        re;
    logic [5:0]  rb;
    logic [6:0]  rt;
    logic        exp_rv;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [NI-1:0] exp_v;
    logic          v;
    logic [31:0]   d;
    int            n;
    int            d0;
    int            any_v;

    vecs[0]  = '{1'b1, 6'd0,  7'd6,   32'h0000_0000, 1'b0, 6'd0,  7'd0,   1'b0, 32'h0};
    vecs[1]  = '{1'b1, 6'd3,  7'd5,   32'hDEAD_BEEF, 1'b0, 6'd0,  7'd0,   1'b0, 32'h0};
    vecs[2]  = '{1'b0, 6'd0,  7'd0,   32'h0,         1'b1, 6'd3,  7'd5,   1'b1, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 6'd25, 7'd5,   32'h1234_5678, 1'b0, 6'd0,  7'd0,   1'b0, 32'h0};
    vecs[4]  = '{1'b0, 6'd0,  7'd0,   32'h0,         1'b1, 6'd25, 7'd5,   1'b1, 32'h0};
    vecs[5]  = '{1'b0, 6'd0,  7'd0,   32'h0,         1'b1, 6'd0,  7'd6,   1'b1, 32'h0};
    vecs[6]  = '{1'b1, 6'd3,  7'd5,   32'h1111_1111, 1'b1, 6'd3,  7'd5,   1'b1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b0, 6'd0,  7'd0,   32'h0,         1'b1, 6'd3,  7'd5,   1'b1, 32'h1111_1111};
    vecs[8]  = '{1'b0, 6'd0,  7'd0,   32'h0,         1'b1, 6'd63, 7'd127, 1'b1, 32'h0};
    vecs[9]  = '{1'b1, 6'd24, 7'd6,   32'hA5A5_A5A5, 1'b0, 6'd0,  7'd0,   1'b0, 32'h0};
    vecs[10] = '{1'b0, 6'd0,  7'd0,   32'h0,         1'b1, 6'd24, 7'd6,   1'b1, 32'hA5A5_A5A5};

    rst = 1'b1;
    wr_en = 1'b0; wr_batch = '0; wr_timestep = '0; wr_data = '0;
    rd_en = 1'b0; rd_batch = '0; rd_timestep = '0;
    start = 1'b0; sim_time = '0; spikes_ready = 1'b0;
`ifdef SPIKE_SEQ_LOOP_EN
    loop_en = 1'b0;
`endif
    tick();
    tick();
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check_vec("rst_spikes", spikes_out, '0);
    check("rst_valid", spikes_valid, 0);
    check("rst_timestep", timestep, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();

    // Host port table: one vector per cycle, read result checked one cycle later.
    for (int k = 0; k < 11; k++) begin
      wr_en = vecs[k].we; wr_batch = vecs[k].wb; wr_timestep = vecs[k].wt; wr_data = vecs[k].wd;
      rd_en = vecs[k].re; rd_batch = vecs[k].rb; rd_timestep = vecs[k].rt;
      tick();
      check($sformatf("tbl%0d_rd_valid", k), rd_valid, vecs[k].exp_rv);
      if (vecs[k].exp_rv) check($sformatf("tbl%0d_rd_data", k), rd_data, vecs[k].exp_rd);
    end
    wr_en = 1'b0; rd_en = 1'b0;
    tick();

    for (int b = 0; b < NB; b++) begin
      host_write(0, b, 32'h1 << b);
      host_write(1, b, {8'hA1, 8'(b), 16'h5A5A ^ 16'(b)});
      host_write(2, b, ~(32'(b) * 32'h0101_0101));
    end

    // Single timestep, ready held high: latency, bit placement, discarded high bits.
    spikes_ready = 1'b1;
    d0 = done_seen;
    pulse_start(1);
    check("a_busy", busy, 1);
    wait_valid("a_wait", n);
    check("a_latency", 32'(n + 1), 27);
    exp_v = '0;
    for (int b = 0; b < 24; b++) exp_v[33 * b] = 1'b1;
    check_vec("a_spikes", spikes_out, exp_v);
    check("a_top_bits", 32'(spikes_out[783:768]), 32'h0);
    check("a_timestep", timestep, 0);
    tick();
    check("a_done", done, 1);
    check("a_busy_fall", busy, 0);
    check("a_valid_drop", spikes_valid, 0);
    tick();
    check("a_done_once", done, 0);
    check("a_done_count", 32'(done_seen - d0), 1);

    // Last batch all ones: only bits 783:768 survive.
    host_write(0, 24, 32'hFFFF_FFFF);
    pulse_start(1);
    wait_valid("b_wait", n);
    check("b_top_bits", 32'(spikes_out[783:768]), 32'hFFFF);
    check("b_no_x", 32'($isunknown(spikes_out)), 0);
    check_vec("b_spikes", spikes_out, assemble(0));
    tick();
    check("b_done", done, 1);
    tick();
    spikes_ready = 1'b0;

    // Three timesteps with back-pressure, start and host writes while busy.
    d0 = done_seen;
    pulse_start(3);
    wait_valid("c_wait0", n);
    check("c_ts0", timestep, 0);
    check_vec("c_spikes0", spikes_out, assemble(0));
    spikes_ready = 1'b1;
    tick();
    spikes_ready = 1'b0;
    check("c_valid_drop", spikes_valid, 0);
    check("c_busy_mid", busy, 1);
    start = 1'b1;
    sim_time = 7'd1;
    tick(); tick(); tick();
    start = 1'b0;
    wait_valid("c_wait1", n);
    check("c_ts1", timestep, 1);
    check_vec("c_spikes1", spikes_out, assemble(1));
    for (int c = 0; c < 10; c++) begin
      wr_en = (c == 0);
      wr_timestep = 7'd0; wr_batch = 6'd0; wr_data = 32'hFFFF_0000;
      rd_en = (c == 1);
      rd_timestep = 7'd0; rd_batch = 6'd0;
      tick();
      check($sformatf("c_stall%0d_valid", c), spikes_valid, 1);
      check($sformatf("c_stall%0d_ts", c), timestep, 1);
      check_vec($sformatf("c_stall%0d_spikes", c), spikes_out, assemble(1));
      if (c == 1) begin
        check("c_busy_rd_valid", rd_valid, 1);
        check("c_busy_rd_data", rd_data, 32'h1);
      end
    end
    wr_en = 1'b0; rd_en = 1'b0;
    check("c_no_early_done", 32'(done_seen - d0), 0);
    spikes_ready = 1'b1;
    tick();
    spikes_ready = 1'b0;
    wait_valid("c_wait2", n);
    check("c_ts2", timestep, 2);
    check_vec("c_spikes2", spikes_out, assemble(2));
    spikes_ready = 1'b1;
    tick();
    spikes_ready = 1'b0;
    check("c_done", done, 1);
    check("c_busy_fall", busy, 0);
    tick();
    check("c_done_count", 32'(done_seen - d0), 1);
    host_read(0, 0, v, d);
    check("c_wr_dropped", d, 32'h1);

    // sim_time of zero: immediate done, never valid.
    d0 = done_seen;
    pulse_start(0);
    check("d_done", done, 1);
    check("d_busy", busy, 0);
    any_v = 0;
    for (int c = 0; c < 30; c++) begin
      if (spikes_valid === 1'b1) any_v++;
      tick();
    end
    check("d_never_valid", 32'(any_v), 0);
    check("d_done_count", 32'(done_seen - d0), 1);

    // Reset during fetch aborts silently; memory survives.
    d0 = done_seen;
    pulse_start(2);
    for (int c = 0; c < 5; c++) tick();
    check("e_busy_pre", busy, 1);
    rst = 1'b1;
    tick();
    check("e_busy", busy, 0);
    check("e_valid", spikes_valid, 0);
    check("e_done", done, 0);
    check("e_timestep", timestep, 0);
    check_vec("e_spikes", spikes_out, '0);
    rst = 1'b0;
    for (int c = 0; c < 40; c++) tick();
    check("e_no_done", 32'(done_seen - d0), 0);
    check("e_idle", busy, 0);
    host_read(5, 3, v, d);
    check("e_mem_kept", d, 32'h1111_1111);

`ifdef SPIKE_SEQ_LOOP_EN
    // Looping replay: 0,1,0,1 with done at each wrap; dropping loop_en ends it.
    spikes_ready = 1'b1;
    loop_en = 1'b1;
    pulse_start(2);
    for (int k = 0; k < 4; k++) begin
      wait_valid($sformatf("f_wait%0d", k), n);
      check($sformatf("f_ts%0d", k), timestep, 32'(k % 2));
      if (k == 3) loop_en = 1'b0;
      tick();
      check($sformatf("f_done%0d", k), done, 32'(k % 2));
      check($sformatf("f_busy%0d", k), busy, (k == 3) ? 32'd0 : 32'd1);
    end
    spikes_ready = 1'b0;
    tick();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
